// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register: a main register and a skid register give a registered
// in_ready_o while still sustaining one transfer per cycle under back-pressure.
module pipe_stage_skid #(
    parameter int                 WIDTH  = 64,
    parameter logic [WIDTH-1:0]   BUBBLE = 64'h0000_0000_0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       occupancy_o
);

    // State encoding equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             accept_s;
    logic             fire_s;

    assign accept_s = in_valid_i & in_ready_q;
    assign fire_s   = out_valid_q & out_ready_i;

    // Next-state and next-storage computation; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    main_d  = in_data_i;
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && fire_s) begin
                    main_d = in_data_i;
                end else if (accept_s) begin
                    skid_d  = in_data_i;
                    state_d = ST_FULL;
                end else if (fire_s) begin
                    main_d  = BUBBLE;
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_FULL: begin
                // in_ready_q is low here, so no accept can occur.
                if (fire_s) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                main_d  = BUBBLE;
                state_d = ST_EMPTY;
            end
        endcase

        if (flush_i) begin
            main_d  = BUBBLE;
            state_d = ST_EMPTY;
        end else begin
            state_d = state_d;
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign out_data_o  = main_q;
    assign out_valid_o = out_valid_q;
    assign in_ready_o  = in_ready_q;
    assign occupancy_o = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: vector table, directed corner sequences
// and a constrained-random run, all checked against a queue scoreboard.
module tb_pipe_stage_skid;

    localparam logic [63:0] BUBBLE = 64'h0000_0000_0000_0013;
    localparam logic [63:0] JUNK   = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [63:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] out_data_o;
    logic [1:0]  occupancy_o;

    int errors = 0;
    int checks = 0;
    int delivered = 0;
    logic [63:0] sb_q[$];

    pipe_stage_skid #(.WIDTH(64), .BUBBLE(BUBBLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .occupancy_o (occupancy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        rdy;
        logic        fl;
        logic [1:0]  e_occ;
        logic        e_valid;
        logic        e_ready;
        logic [63:0] e_data;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("occupancy", 64'(occupancy_o), 64'(sb_q.size()));
        chk("out_valid", 64'(out_valid_o), 64'(sb_q.size() != 0));
        chk("in_ready",  64'(in_ready_o),  64'(sb_q.size() < 2));
        chk("out_data",  out_data_o, (sb_q.size() != 0) ? sb_q[0] : BUBBLE);
    endtask

    // One clock: drive inputs, update scoreboard from the handshake, then check state.
    task automatic cycle(input logic v, input logic [63:0] d, input logic rdy, input logic fl);
        logic acc;
        logic fir;
        in_valid_i  = v;
        in_data_i   = v ? d : JUNK;
        out_ready_i = rdy;
        flush_i     = fl;
        acc = v & in_ready_o;
        fir = out_valid_o & rdy;
        if (fir) begin
            chk("fire_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                chk("fire_data", out_data_o, sb_q[0]);
                void'(sb_q.pop_front());
                delivered++;
            end
        end
        if (fl) sb_q.delete();
        else if (acc) sb_q.push_back(d);
        @(posedge clk);
        #1;
        check_state();
    endtask

    initial begin
        int d0;
        // Reset held for two cycles while upstream offers data.
        rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 64'hAAAA_AAAA_0000_00B3;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid_i = 1'b0; in_data_i = JUNK;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_data",  out_data_o, BUBBLE);
        chk("rst_ready", 64'(in_ready_o), 64'd1);
        chk("rst_occ",   64'(occupancy_o), 64'd0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0);

        // Vector table: fill, back-pressure, drain, refill, flush while full.
        vecs[0]  = '{1'b1, 64'h11, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 64'h11};
        vecs[1]  = '{1'b1, 64'h22, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 64'h22};
        vecs[2]  = '{1'b1, 64'h33, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 64'h22};
        vecs[3]  = '{1'b1, 64'h44, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 64'h22};
        vecs[4]  = '{1'b1, 64'h44, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 64'h22};
        vecs[5]  = '{1'b0, 64'h0,  1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 64'h33};
        vecs[6]  = '{1'b0, 64'h0,  1'b1, 1'b0, 2'd0, 1'b0, 1'b1, BUBBLE};
        vecs[7]  = '{1'b1, 64'h55, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 64'h55};
        vecs[8]  = '{1'b1, 64'h66, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 64'h55};
        vecs[9]  = '{1'b1, 64'h77, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, BUBBLE};
        vecs[10] = '{1'b0, 64'h0,  1'b1, 1'b0, 2'd0, 1'b0, 1'b1, BUBBLE};
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].rdy, vecs[i].fl);
            chk("vec_occ",   64'(occupancy_o), 64'(vecs[i].e_occ));
            chk("vec_valid", 64'(out_valid_o), 64'(vecs[i].e_valid));
            chk("vec_ready", 64'(in_ready_o),  64'(vecs[i].e_ready));
            chk("vec_data",  out_data_o, vecs[i].e_data);
        end

        // Streaming: eight back-to-back payloads with the sink always ready.
        d0 = delivered;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, {32'(4 * k + 4), 32'h0010_0093 + 32'(k)}, 1'b1, 1'b0);
            chk("stream_occ", 64'(occupancy_o), 64'd1);
        end
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        chk("stream_count", 64'(delivered - d0), 64'd8);

        // Drain to empty from a single payload.
        cycle(1'b1, 64'h0000_0008_0000_0513, 1'b0, 1'b0);
        chk("drain_head", out_data_o, 64'h0000_0008_0000_0513);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        chk("drain_valid", 64'(out_valid_o), 64'd0);
        chk("drain_data",  out_data_o, BUBBLE);

        // Reset while full loses both entries.
        cycle(1'b1, 64'hA1, 1'b0, 1'b0);
        cycle(1'b1, 64'hA2, 1'b0, 1'b0);
        chk("pre_rst_occ", 64'(occupancy_o), 64'd2);
        rst = 1'b1; in_valid_i = 1'b1; in_data_i = 64'hA3; out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid_i = 1'b0; in_data_i = JUNK;
        sb_q.delete();
        check_state();
        chk("midrst_data", out_data_o, BUBBLE);

        // Constrained-random traffic against the scoreboard.
        for (int c = 0; c < 10000; c++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  {$urandom, $urandom},
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 63) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised, elastic pipeline register that replaces fixed inter-stage registers such as IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries a WIDTH-bit payload with valid/ready handshake on both sides.
- A two-entry skid buffer keeps throughput at one transfer per cycle under back-pressure while registering in_ready_o, so there is no combinational ready path between stages.
- Supports a synchronous flush for branch/jump squash, and drives a configurable bubble pattern (default RISC-V NOP) whenever empty.

Parameters:
WIDTH, 64, payload width; default packs {pc_incr[31:0], instr[31:0]}.
BUBBLE, 64'h0000_0000_0000_0013, value driven on out_data_o when the stage holds no valid entry (low word = addi x0,x0,0).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
flush_i  input  1  squash all held entries at next edge
in_valid_i  input  1  upstream offers in_data_i
in_ready_o  input/output: output  1  stage can accept; registered
in_data_i  input  WIDTH  upstream payload
out_valid_o  output  1  out_data_o holds a valid entry
out_ready_i  input  1  downstream accepts out_data_o this cycle
out_data_o  output  WIDTH  head payload, or BUBBLE when empty
occupancy_o  output  2  entries held: 0, 1 or 2

Behaviour:
- Handshake terms:
  - accept = in_valid_i & in_ready_o.
  - fire = out_valid_o & out_ready_i.
- Storage: main register (head, drives out_data_o) and skid register. out_data_o, out_valid_o, in_ready_o and occupancy_o all come straight from flops.
- State machine (encoded by occupancy):
  - EMPTY (occ 0): out_valid_o=0, out_data_o=BUBBLE, in_ready_o=1. accept -> main<=in_data_i, go to ONE.
  - ONE (occ 1): out_valid_o=1, in_ready_o=1.
    - accept & fire -> main<=in_data_i, stay in ONE.
    - accept & !fire -> skid<=in_data_i, go to FULL.
    - !accept & fire -> main<=BUBBLE, go to EMPTY.
    - Otherwise hold.
  - FULL (occ 2): out_valid_o=1, in_ready_o=0.
    - fire -> main<=skid, go to ONE, in_ready_o=1 next cycle.
    - Otherwise hold.
    - in_valid_i is ignored in this state.
- Latency: a payload accepted at edge N is visible on out_data_o after edge N (one cycle), when the stage was EMPTY, or ONE with fire.
- Throughput: one transfer per cycle sustained while out_ready_i=1.
- Ordering: strict FIFO; no payload is ever duplicated or dropped except by flush or rst.
- Held data stability: while out_valid_o=1 and out_ready_i=0, out_data_o and out_valid_o must not change.
- flush_i:
  - At the next edge: state<=EMPTY, main<=BUBBLE, skid contents don't-care, in_ready_o<=1.
  - Any same-cycle accept is discarded.
  - A same-cycle fire still counts as delivered downstream; the stage takes no action.
  - flush_i has priority over every other transition.
- rst: same effect as flush_i and dominates it.
  - Reset values: out_valid_o=0, out_data_o=BUBBLE, in_ready_o=1, occupancy_o=0.
  - rst asserted mid-transfer loses both entries; no partial state survives.
- Skid register is only written from ONE with accept & !fire; X on in_data_i while in_valid_i=0 must never reach out_data_o.
- A stall of the old style (hold stage) is expressed as out_ready_i=0; a bubble insertion is expressed as in_valid_i=0.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid_i=1, in_data_i=64'hAAAA_AAAA_0000_00B3 -> out_valid_o=0, out_data_o=64'h13, in_ready_o=1, occupancy_o=0 after release.
- Streaming: push 8 payloads {pc=4*k+4, instr=32'h0010_0093+k} back to back with out_ready_i=1 -> each emerges one cycle later in order; occupancy_o stays 1; in_ready_o never drops.
- Back-pressure: stream, then drop out_ready_i for 3 cycles -> occupancy goes 1->2; in_ready_o=0 from the second cycle; head is held stable; on release both entries drain in order with no loss or duplicate.
- Flush while FULL with a simultaneous in_valid_i=1 -> next cycle out_valid_o=0, out_data_o=64'h13, occupancy_o=0; the flushed and offered payloads never appear.
- Drain to empty: single payload 64'h0000_0008_0000_0513, then out_ready_i=1 and in_valid_i=0 -> after the fire, out_valid_o=0 and out_data_o returns to BUBBLE.
- Random: constrained-random in_valid_i/out_ready_i/flush_i over 10k cycles against a queue scoreboard -> no ordering errors; in_ready_o=0 only when occupancy_o=2.
